mld_15_7_encoder: RTL and testbench

Systematic serial encoder for the (15,7) cyclic code, generator g(x) = 1 + x^4 + x^6 + x^7 + x^8. It is the transmit-side partner of the (15,7) majority-logic decoder.
- Accepts a 7-bit message over a valid/ready handshake.
- Emits the 15-bit codeword serially, highest-order coefficient first.
- Emits a load strobe in the format the decoder consumes: load high for 15 bit-cycles, then low for the correction window.

---
 rtl/mld_15_7_pkg.sv | 23 ++
 rtl/mld_15_7_parity_lfsr.sv | 55 +++++
 rtl/mld_15_7_encoder.sv | 193 +++++++++++++++++++
 tb/tb_mld_15_7_encoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mld_15_7_pkg.sv
// ----------------------------------------------------------------------------
// mld_15_7_pkg
// Shared constants and types for the (15,7) cyclic code blocks.
//   N, K, R   : codeword length, message length, parity length
//   GEN_POLY  : generator g(x) = 1 + x^4 + x^6 + x^7 + x^8, bit j = g_j
//   state_e   : serial encoder frame states
// ----------------------------------------------------------------------------
package mld_15_7_pkg;

    localparam int N = 15;
    localparam int K = 7;
    localparam int R = 8;

    localparam logic [R:0] GEN_POLY = 9'b1_1101_0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        PAR  = 2'd2,
        GAP  = 2'd3
    } state_e;

endpackage

// File: rtl/mld_15_7_parity_lfsr.sv
// ----------------------------------------------------------------------------
// mld_15_7_parity_lfsr
// 8-bit Galois-style division register for g(x). With feedback enabled each
// shift computes r <- (x*r + in*x^8) mod g(x); with feedback disabled it is a
// plain shift register that empties the remainder out of b7, filling with 0.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset, clears the register
//   clear       in   synchronous clear (wins over shift)
//   shift       in   advance the register one step
//   feedback_en in   1: divide by g(x), 0: plain shift with fb forced to 0
//   in_bit      in   serial input coefficient (used when feedback_en=1)
//   b7          out  most significant remainder bit
// ----------------------------------------------------------------------------
module mld_15_7_parity_lfsr
    import mld_15_7_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic shift,
    input  logic feedback_en,
    input  logic in_bit,
    output logic b7
);

    logic [R-1:0] lfsr_q;
    logic [R-1:0] lfsr_d;
    logic         fb;

    always_comb begin
        fb     = feedback_en & (in_bit ^ lfsr_q[R-1]);
        lfsr_d = lfsr_q;
        if (clear) begin
            lfsr_d = '0;
        end else if (shift) begin
            // Taps follow the generator coefficients g0..g7.
            lfsr_d[0] = fb & GEN_POLY[0];
            for (int j = 1; j < R; j++) begin
                lfsr_d[j] = lfsr_q[j-1] ^ (fb & GEN_POLY[j]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign b7 = lfsr_q[R-1];

endmodule

// File: rtl/mld_15_7_encoder.sv
// ----------------------------------------------------------------------------
// mld_15_7_encoder
// Systematic serial encoder for the (15,7) cyclic code. Accepts a 7-bit
// message on a valid/ready handshake and emits c14..c0 one bit per clock,
// followed by GAP_CYCLES idle cycles that form the decoder correction window.
// Parameters:
//   GAP_CYCLES  idle cycles after each codeword (0..255)
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   msg_valid   in   message word offered
//   msg_ready   out  encoder accepts a message this cycle
//   message     in   [0:6] message bits, message[i] = m_i
//   code_bit    out  serial codeword bit, c14 first
//   code_valid  out  code_bit meaningful
//   code_load   out  decoder load strobe (same as code_valid)
//   code_first  out  cycle carrying c14
//   code_last   out  cycle carrying c0
// All outputs come straight from registers.
// ----------------------------------------------------------------------------
module mld_15_7_encoder
    import mld_15_7_pkg::*;
#(
    parameter int GAP_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [0:6] message,
    output logic       code_bit,
    output logic       code_valid,
    output logic       code_load,
    output logic       code_first,
    output logic       code_last
);

    localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [3:0] MSG_LAST = 4'(K - 1);
    localparam logic [3:0] PAR_LAST = 4'(R - 1);

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [0:6] msg_q, msg_d;
    logic       msg_ready_q, msg_ready_d;
    logic       code_bit_q, code_bit_d;
    logic       code_valid_q, code_valid_d;
    logic       code_first_q, code_first_d;
    logic       code_last_q, code_last_d;

    logic       accept;
    logic [2:0] nxt_idx;
    logic       lfsr_clear;
    logic       lfsr_shift;
    logic       lfsr_fb_en;
    logic       lfsr_in;
    logic       lfsr_b7;

    mld_15_7_parity_lfsr u_lfsr (
        .clk         (clk),
        .reset       (reset),
        .clear       (lfsr_clear),
        .shift       (lfsr_shift),
        .feedback_en (lfsr_fb_en),
        .in_bit      (lfsr_in),
        .b7          (lfsr_b7)
    );

    assign accept  = msg_valid & msg_ready_q;
    // While code_bit shows m_(6-cnt), the next message bit to load is m_(5-cnt).
    assign nxt_idx = 3'd5 - bit_cnt_q[2:0];

    // The LFSR absorbs each message bit on the same edge that loads it into
    // code_bit, so after the last MSG edge it already holds the full remainder
    // and b7 can be registered straight out as c7.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        msg_d        = msg_q;
        msg_ready_d  = msg_ready_q;
        code_bit_d   = 1'b0;
        code_valid_d = 1'b0;
        code_first_d = 1'b0;
        code_last_d  = 1'b0;
        lfsr_clear   = 1'b0;
        lfsr_shift   = 1'b0;
        lfsr_fb_en   = 1'b0;
        lfsr_in      = 1'b0;

        unique case (state_q)
            IDLE: begin
                msg_ready_d = 1'b1;
                lfsr_clear  = 1'b1;
                if (accept) begin
                    msg_d        = message;
                    msg_ready_d  = 1'b0;
                    state_d      = MSG;
                    bit_cnt_d    = 4'd0;
                    code_bit_d   = message[6];
                    code_valid_d = 1'b1;
                    code_first_d = 1'b1;
                    lfsr_clear   = 1'b0;
                    lfsr_shift   = 1'b1;
                    lfsr_fb_en   = 1'b1;
                    lfsr_in      = message[6];
                end
            end

            MSG: begin
                code_valid_d = 1'b1;
                lfsr_shift   = 1'b1;
                if (bit_cnt_q == MSG_LAST) begin
                    // Hand over to parity: present c7 and start draining.
                    code_bit_d = lfsr_b7;
                    state_d    = PAR;
                    bit_cnt_d  = 4'd0;
                end else begin
                    code_bit_d = msg_q[nxt_idx];
                    lfsr_fb_en = 1'b1;
                    lfsr_in    = msg_q[nxt_idx];
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                end
            end

            PAR: begin
                if (bit_cnt_q == PAR_LAST) begin
                    bit_cnt_d = 4'd0;
                    if (GAP_CYCLES == 0) begin
                        state_d     = IDLE;
                        msg_ready_d = 1'b1;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = 8'd0;
                    end
                end else begin
                    code_bit_d   = lfsr_b7;
                    code_valid_d = 1'b1;
                    code_last_d  = (bit_cnt_q == PAR_LAST - 4'd1);
                    lfsr_shift   = 1'b1;
                    bit_cnt_d    = bit_cnt_q + 4'd1;
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d     = IDLE;
                    msg_ready_d = 1'b1;
                    gap_cnt_d   = 8'd0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            gap_cnt_q    <= 8'd0;
            msg_q        <= '0;
            msg_ready_q  <= 1'b0;
            code_bit_q   <= 1'b0;
            code_valid_q <= 1'b0;
            code_first_q <= 1'b0;
            code_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            msg_q        <= msg_d;
            msg_ready_q  <= msg_ready_d;
            code_bit_q   <= code_bit_d;
            code_valid_q <= code_valid_d;
            code_first_q <= code_first_d;
            code_last_q  <= code_last_d;
        end
    end

    assign msg_ready  = msg_ready_q;
    assign code_bit   = code_bit_q;
    assign code_valid = code_valid_q;
    assign code_load  = code_valid_q;
    assign code_first = code_first_q;
    assign code_last  = code_last_q;

endmodule

// File: tb/tb_mld_15_7_encoder.sv
module tb_mld_15_7_encoder;

    localparam int GAP = 15;

    logic       clk;
    logic       reset;
    logic       msg_valid, msg_ready;
    logic [0:6] message;
    logic       code_bit, code_valid, code_load, code_first, code_last;

    logic       msg_valid0, msg_ready0;
    logic [0:6] message0;
    logic       code_bit0, code_valid0, code_load0, code_first0, code_last0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [14:0] exp_q[$];
    logic [14:0] cw0_q[$];
    int          f0_q[$];

    mld_15_7_encoder #(.GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .message(message), .code_bit(code_bit), .code_valid(code_valid),
        .code_load(code_load), .code_first(code_first), .code_last(code_last)
    );

    mld_15_7_encoder #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .msg_valid(msg_valid0), .msg_ready(msg_ready0),
        .message(message0), .code_bit(code_bit0), .code_valid(code_valid0),
        .code_load(code_load0), .code_first(code_first0), .code_last(code_last0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required below 1ms", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within its cycle budget (cycle %0d)", nm, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference encoder by polynomial long division of x^8*m(x) by g(x).
    function automatic logic [14:0] model(input logic [0:6] m);
        logic [14:0] c;
        logic [14:0] r;
        c = '0;
        for (int i = 0; i < 7; i++) c[8+i] = m[i];
        r = c;
        for (int d = 14; d >= 8; d--)
            if (r[d]) r = r ^ (15'h1D1 << (d - 8));
        c[7:0] = r[7:0];
        return c;
    endfunction

    // ---------------- scoreboard monitor for the GAP=15 instance ----------
    logic [14:0] mon_cw = '0;
    int mon_n = 0, mon_load = 0, mon_first_cyc = 0, mon_last_cyc = 0, frames_done = 0;
    bit mon_active = 0;

    always @(negedge clk) begin
        if (!reset) begin
            mon_active = 0;
            mon_n      = 0;
        end else if (code_valid) begin
            if (code_first) begin
                if (mon_active) fail_now("first_inside_frame");
                mon_active    = 1;
                mon_n         = 0;
                mon_load      = 0;
                mon_cw        = '0;
                mon_first_cyc = cyc;
            end
            if (mon_active) begin
                mon_cw = {mon_cw[13:0], code_bit};
                mon_n++;
                if (code_load) mon_load++;
                if (code_last) begin
                    chk("frame_len", mon_n, 15);
                    chk("load_cycles", mon_load, 15);
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_frame");
                    end else begin
                        chk("codeword", mon_cw, exp_q.pop_front());
                    end
                    mon_active   = 0;
                    mon_last_cyc = cyc;
                    frames_done++;
                end
            end else begin
                fail_now("bit_without_first");
            end
        end
    end

    // ---------------- collector for the GAP=0 instance --------------------
    logic [14:0] cw0 = '0;
    int f0 = 0;
    always @(negedge clk) begin
        if (reset && code_valid0) begin
            if (code_first0) begin
                cw0 = '0;
                f0  = cyc;
            end
            cw0 = {cw0[13:0], code_bit0};
            if (code_last0) begin
                cw0_q.push_back(cw0);
                f0_q.push_back(f0);
            end
        end
    end

    int acc_cyc = 0;

    task automatic send(input logic [0:6] m, input logic [14:0] exp);
        int n = 0;
        while (!msg_ready && n < 100) begin tick(); n++; end
        if (!msg_ready) begin
            fail_now("ready_wait");
            return;
        end
        message   = m;
        msg_valid = 1'b1;
        exp_q.push_back(exp);
        acc_cyc   = cyc;
        tick();
        msg_valid = 1'b0;
        message   = ~m;
    endtask

    task automatic run_frame(input logic [0:6] m, input logic [14:0] exp, input bit poke);
        int fd;
        int n;
        fd = frames_done;
        send(m, exp);
        if (poke) begin
            message   = 7'b1111111;
            msg_valid = 1'b1;
            repeat (5) tick();
            msg_valid = 1'b0;
        end
        n = 0;
        while (frames_done == fd && n < 100) begin tick(); n++; end
        if (frames_done == fd) begin
            fail_now("frame_done");
            exp_q.delete();
        end
        chk("first_latency", mon_first_cyc - acc_cyc, 1);
        chk("last_latency", mon_last_cyc - acc_cyc, 15);
        n = 0;
        while (!msg_ready && n < 100) begin tick(); n++; end
        chk("ready_latency", cyc - acc_cyc, 16 + GAP);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        msg_valid  = 1'b0;
        message    = '0;
        msg_valid0 = 1'b0;
        message0   = '0;
        #1 reset   = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", {msg_ready, code_bit, code_valid, code_load, code_first, code_last}, 0);
        chk("reset_outputs0", {msg_ready0, code_valid0, code_load0, code_first0, code_last0}, 0);
        #2 reset = 1'b1;
        chk("ready_at_release", msg_ready, 0);
        tick();
        chk("ready_after_release", msg_ready, 1);

        run_frame(7'b0000000, 15'b000000000000000, 0);
        run_frame(7'b1000000, 15'b000000111010001, 0);
        run_frame(7'b0000001, 15'b100000011101000, 0);
        run_frame(7'b1111111, 15'b111111111111111, 0);
        run_frame(7'b0100000, 15'b000001001110011, 1);
        run_frame(7'b0001000, 15'b000100000011101, 0);
        run_frame(7'b1000001, 15'b100000100111001, 0);

        // Abort a frame while its 5th code bit is on the wire.
        send(7'b1111111, 15'b111111111111111);
        repeat (4) tick();
        chk("mid_frame_valid", code_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", {msg_ready, code_bit, code_valid, code_load, code_first, code_last}, 0);
        exp_q.delete();
        repeat (2) tick();
        #2 reset = 1'b1;
        chk("ready_at_release2", msg_ready, 0);
        tick();
        chk("ready_after_release2", msg_ready, 1);
        run_frame(7'b0000001, 15'b100000011101000, 0);

        for (int i = 0; i < 128; i++) run_frame(7'(i), model(7'(i)), 0);

        // Back-to-back frames on the zero-gap instance.
        message0   = 7'b0000001;
        msg_valid0 = 1'b1;
        n = 0;
        while (cw0_q.size() < 3 && n < 200) begin tick(); n++; end
        msg_valid0 = 1'b0;
        if (cw0_q.size() < 3) begin
            fail_now("gap0_frames");
        end else begin
            for (int k = 0; k < 3; k++) chk("gap0_codeword", cw0_q[k], 15'b100000011101000);
            for (int k = 1; k < 3; k++) chk("gap0_period", f0_q[k] - f0_q[k-1], 16);
        end

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
